// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg
// Shared constants for the 7-segment scan driver: active-low segment
// patterns for the decimal digits, the blank and dash patterns, the
// all-anodes-off value and a helper that turns a digit index into a
// one-hot-low anode vector.
// Segment vectors are ordered {g,f,e,d,c,b,a}; a 0 lights the segment.
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Digit index 0 is the rightmost digit, driven by an[0].
  function automatic logic [3:0] anode_select(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg
// Combinational BCD nibble to active-low 7-segment pattern decoder.
// Nibbles above 9 are not valid BCD and are shown as a single dash so a
// corrupted value is visible on the display instead of a random glyph.
// Ports:
//   nibble  in  4  BCD digit
//   seg     out 7  {g,f,e,d,c,b,a}, active-low
module bcd_to_7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
// Time-multiplexes two packed-BCD bytes onto a 4-digit common-anode
// 7-segment display. Each frame is four digit slots of REFRESH_DIV cycles;
// the first BLANK_CYCLES of every slot keep all anodes off so the previous
// digit's segments cannot ghost onto the next anode. Inputs are snapshotted
// once per frame so a value changing mid-frame never tears. The left-pair
// tens digit can be suppressed when zero (LZ_BLANK_LEFT).
// Optional feature: define SEVENSEG_BLINK_EN to blink digits 3..2 while
// blink_left is set; without it blink_left is ignored.
// Ports:
//   clk            in  1  system clock
//   rst            in  1  synchronous active-high reset
//   display_left   in  8  BCD, [7:4] -> digit 3, [3:0] -> digit 2
//   display_right  in  8  BCD, [7:4] -> digit 1, [3:0] -> digit 0
//   blink_left     in  1  blink request for digits 3..2
//   an             out 4  anode enables, active-low, an[0] = rightmost
//   seg            out 7  {g,f,e,d,c,b,a}, active-low
//   dp             out 1  decimal point, active-low, always off
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_CYCLES  = 16,
  parameter int LZ_BLANK_LEFT = 1,
  parameter int BLINK_DIV     = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] display_left,
  input  logic [7:0] display_right,
  input  logic       blink_left,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END    = PW'(BLANK_CYCLES);

  logic [PW-1:0] prescaler;
  logic [1:0]    digit_idx;
  logic [7:0]    shadow_left;
  logic [7:0]    shadow_right;
  logic          tick;
  logic          frame_start;
  logic [7:0]    cur_left;
  logic [7:0]    cur_right;
  logic [3:0]    nibble;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;
  logic          in_blank;
  logic          lz_mute;
  logic          blink_mute;
  logic          unused_cfg;

  assign tick        = (prescaler == PRESCALE_MAX);
  assign frame_start = (prescaler == '0) && (digit_idx == 2'd0);
  assign in_blank    = (prescaler < BLANK_END);
  assign dp          = 1'b1;

  // In the snapshot cycle the freshly sampled inputs are what the shadow
  // will hold, so decode from them directly; this keeps the frame coherent
  // even when BLANK_CYCLES is zero and slot 0 is visible immediately.
  assign cur_left  = frame_start ? display_left  : shadow_left;
  assign cur_right = frame_start ? display_right : shadow_right;

  // blink_left and BLINK_DIV only matter when blinking is compiled in.
  assign unused_cfg = blink_left ^ (BLINK_DIV > 0);

  // Pick the nibble belonging to the digit currently being scanned.
  always_comb begin
    nibble = cur_right[3:0];
    case (digit_idx)
      2'd0: nibble = cur_right[3:0];
      2'd1: nibble = cur_right[7:4];
      2'd2: nibble = cur_left[3:0];
      2'd3: nibble = cur_left[7:4];
      default: nibble = cur_right[3:0];
    endcase
  end

  bcd_to_7seg u_decoder (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  assign lz_mute = (LZ_BLANK_LEFT != 0) && (digit_idx == 2'd3) &&
                   (cur_left[7:4] == 4'd0);

`ifdef SEVENSEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          shadow_blink;
  logic          cur_blink;

  assign cur_blink  = frame_start ? blink_left : shadow_blink;
  assign blink_mute = !blink_phase && cur_blink && digit_idx[1];

  // Free-running blink timebase; phase 1 means the digits are visible.
  // The blink request is captured with the frame data so it cannot tear.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt    <= '0;
      blink_phase  <= 1'b1;
      shadow_blink <= 1'b0;
    end else begin
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      if (frame_start) begin
        shadow_blink <= blink_left;
      end
    end
  end
`else
  assign blink_mute = 1'b0;
`endif

  // Next output values; the anode still scans while a digit is muted so
  // the duty cycle of the remaining digits does not change.
  always_comb begin
    an_next  = ANODE_OFF;
    seg_next = SEG_BLANK;
    if (!in_blank) begin
      an_next = anode_select(digit_idx);
      if (lz_mute || blink_mute) begin
        seg_next = SEG_BLANK;
      end else begin
        seg_next = dec_seg;
      end
    end
  end

  // Slot timing, frame snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler    <= '0;
      digit_idx    <= 2'd0;
      shadow_left  <= 8'h00;
      shadow_right <= 8'h00;
      an           <= ANODE_OFF;
      seg          <= SEG_BLANK;
    end else begin
      if (tick) begin
        prescaler <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      if (frame_start) begin
        shadow_left  <= display_left;
        shadow_right <= display_right;
      end
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver
// Scoreboard bench for sevenseg_scan_driver. The stimulus side drives the
// inputs each cycle and pushes the display state expected after the next
// clock edge, computed from elapsed time since reset with plain arithmetic;
// a monitor pops one entry per clock and compares it with the pins.
// Honours SEVENSEG_BLINK_EN the same way the design does.
module tb_sevenseg_scan_driver;

  localparam int REFRESH_DIV  = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int BLINK_DIV    = 64;
  localparam int FRAME        = 4 * REFRESH_DIV;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] display_left = 8'h00;
  logic [7:0] display_right = 8'h00;
  logic       blink_left = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  exp_t exp_q[$];
  exp_t got_e;
  int   checks = 0;
  int   passes = 0;
  int   mon_cycle = 0;

  // Reference model state: k = clock edges seen since reset was released.
  int         k = 0;
  logic [7:0] snap_l = 8'h00;
  logic [7:0] snap_r = 8'h00;
  logic       snap_b = 1'b0;
  logic [6:0] digit_pat [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                  7'b0110000, 7'b0011001, 7'b0010010,
                                  7'b0000010, 7'b1111000, 7'b0000000,
                                  7'b0010000};

  always #5 clk = ~clk;

  sevenseg_scan_driver #(
    .REFRESH_DIV   (REFRESH_DIV),
    .BLANK_CYCLES  (BLANK_CYCLES),
    .LZ_BLANK_LEFT (1),
    .BLINK_DIV     (BLINK_DIV)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .display_left  (display_left),
    .display_right (display_right),
    .blink_left    (blink_left),
    .an            (an),
    .seg           (seg),
    .dp            (dp)
  );

  // Expected display after one clock edge with the given inputs.
  function automatic exp_t model_edge(input logic r, input logic [7:0] l,
                                      input logic [7:0] rt, input logic b);
    exp_t e;
    int   p, slot, nib;
    e.an  = 4'b1111;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    if (r) begin
      k = 0;
    end else begin
      p    = k % REFRESH_DIV;
      slot = (k / REFRESH_DIV) % 4;
      if (p == 0 && slot == 0) begin
        snap_l = l;
        snap_r = rt;
        snap_b = b;
      end
      if (p >= BLANK_CYCLES) begin
        e.an[slot] = 1'b0;
        case (slot)
          0:       nib = int'(snap_r) % 16;
          1:       nib = int'(snap_r) / 16;
          2:       nib = int'(snap_l) % 16;
          default: nib = int'(snap_l) / 16;
        endcase
        e.seg = (nib > 9) ? 7'b0111111 : digit_pat[nib];
        if (slot == 3 && (int'(snap_l) / 16) == 0) e.seg = 7'h7F;
`ifdef SEVENSEG_BLINK_EN
        if (snap_b && ((k / BLINK_DIV) % 2 == 1) && slot >= 2) e.seg = 7'h7F;
`endif
      end
      k = k + 1;
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic r, input logic [7:0] l,
                               input logic [7:0] rt, input logic b,
                               input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst           = r;
      display_left  = l;
      display_right = rt;
      blink_left    = b;
      exp_q.push_back(model_edge(r, l, rt, b));
    end
  endtask

  // Hold inputs until the next edge lands on the given cycle of the frame.
  task automatic runUntil(input int frame_pos, input logic [7:0] l,
                          input logic [7:0] rt, input logic b);
    for (int i = 0; i < FRAME && (k % FRAME) != frame_pos; i++) begin
      applyStimulus(1'b0, l, rt, b, 1);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checks = checks + 1;
    if ({an, seg, dp} === e) begin
      passes = passes + 1;
    end else begin
      $display("[TB] FAIL display cycle %0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               mon_cycle, an, seg, dp, e.an, e.seg, e.dp);
    end
  endtask

  // Monitor: the display presents a new state every clock.
  always @(posedge clk) begin
    #1;
    mon_cycle = mon_cycle + 1;
    if (exp_q.size() > 0) begin
      got_e = exp_q.pop_front();
      checkOutput(got_e);
    end
  end

  initial begin
    logic [7:0] rl, rr;
    logic       rb, rrst;
    int         n;

    $display("[TB] reset and basic frame");
    applyStimulus(1'b1, 8'h25, 8'h07, 1'b0, 3);
    applyStimulus(1'b0, 8'h25, 8'h07, 1'b0, 2 * FRAME);

    $display("[TB] leading zero and dash");
    applyStimulus(1'b0, 8'h05, 8'h3A, 1'b0, 2 * FRAME);

    $display("[TB] score 00 with blank left tens");
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, FRAME + 4);

    $display("[TB] mid-frame input change");
    runUntil(0, 8'h25, 8'h07, 1'b0);
    applyStimulus(1'b0, 8'h25, 8'h07, 1'b0, REFRESH_DIV + 3);
    applyStimulus(1'b0, 8'h19, 8'h07, 1'b0, 2 * FRAME);

    $display("[TB] reset during slot 2");
    runUntil(2 * REFRESH_DIV + 3, 8'h25, 8'h07, 1'b0);
    applyStimulus(1'b1, 8'h48, 8'h13, 1'b0, 1);
    applyStimulus(1'b0, 8'h48, 8'h13, 1'b0, FRAME + 8);

    $display("[TB] randomized inputs");
    for (int it = 0; it < 60; it++) begin
      rl   = 8'($urandom);
      rr   = 8'($urandom);
      rb   = 1'($urandom_range(0, 1));
      rrst = ($urandom_range(0, 11) == 0);
      n    = $urandom_range(1, 48);
      if (rrst) applyStimulus(1'b1, rl, rr, rb, $urandom_range(1, 3));
      applyStimulus(1'b0, rl, rr, rb, n);
    end

    $display("[TB] blink request");
    applyStimulus(1'b1, 8'h12, 8'h34, 1'b1, 1);
    applyStimulus(1'b0, 8'h12, 8'h34, 1'b1, 4 * BLINK_DIV + 8);

    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
